// File: rtl/mu_broadcast_sched_if.sv
// mu_broadcast_sched_if
// Groups the arbitration and broadcast signals of the motion-update
// broadcast scheduler.
//   src_valid / src_last / src_data / src_dst_cell : requests from the
//       NUM_SRC motion-update pipelines (source i occupies slice i)
//   src_ready   : one-hot grant back to the pipelines
//   out_data / out_data_dst_cell / out_data_valid : registered broadcast
//       bus snooped by every cell cache
// Modports:
//   master : the pipeline/cache side (drives requests, observes grant and bus)
//   slave  : the scheduler (consumes requests, drives grant and bus)
interface mu_broadcast_sched_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_SRC       = 4
) ();
    logic [NUM_SRC-1:0]                 src_valid;
    logic [NUM_SRC-1:0]                 src_last;
    logic [NUM_SRC*3*DATA_WIDTH-1:0]    src_data;
    logic [NUM_SRC*3*CELL_ID_WIDTH-1:0] src_dst_cell;
    logic [NUM_SRC-1:0]                 src_ready;
    logic [3*DATA_WIDTH-1:0]            out_data;
    logic [3*CELL_ID_WIDTH-1:0]         out_data_dst_cell;
    logic                               out_data_valid;

    modport master (
        output src_valid, src_last, src_data, src_dst_cell,
        input  src_ready, out_data, out_data_dst_cell, out_data_valid
    );

    modport slave (
        input  src_valid, src_last, src_data, src_dst_cell,
        output src_ready, out_data, out_data_dst_cell, out_data_valid
    );
endinterface

// File: rtl/mu_broadcast_sched.sv
// mu_broadcast_sched
// Sequences one motion-update pass over the double-buffered position caches.
// During BROADCAST it round-robin arbitrates the motion-update pipelines onto
// the single registered broadcast bus, keeps the cache enable high through
// FLUSH, then holds the enable low for SWAP_WAIT cycles so the caches can
// write their particle counts and swap buffers before done pulses.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : one-cycle pulse, only honoured in IDLE
//   bus (slave modport)   : pipeline requests, one-hot grant, broadcast bus
//   motion_update_enable  : cache enable, high in BROADCAST and FLUSH
//   busy                  : high whenever not IDLE
//   done                  : one-cycle pulse at end of pass
//   broadcast_count       : particles broadcast in the current/last pass
module mu_broadcast_sched #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_SRC       = 4,
    parameter int SWAP_WAIT     = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    mu_broadcast_sched_if.slave  bus,
    output logic                 motion_update_enable,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] broadcast_count
);
    localparam int PW    = 3 * DATA_WIDTH;
    localparam int CW    = 3 * CELL_ID_WIDTH;
    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int SW_W  = $clog2(SWAP_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BROADCAST,
        S_FLUSH,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_SRC-1:0]   finished_q, finished_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [SW_W-1:0]      settle_q, settle_d;
    logic [PW-1:0]        out_data_q, out_data_d;
    logic [CW-1:0]        out_cell_q, out_cell_d;
    logic                 out_valid_q, out_valid_d;

    logic [NUM_SRC-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_found;
    logic [PTR_W-1:0]     cand;
    int                   cand_int;

    // Round-robin search starting at the pointer; finished sources are
    // skipped so a source that has signalled last is never granted again.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        cand_int    = 0;
        if (state_q == S_BROADCAST) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cand_int = int'(ptr_q) + k;
                if (cand_int >= NUM_SRC) begin
                    cand_int = cand_int - NUM_SRC;
                end
                cand = PTR_W'(cand_int);
                if (!grant_found && bus.src_valid[cand] && !finished_q[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                    grant[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        finished_d  = finished_q;
        count_d     = count_q;
        settle_d    = settle_q;
        out_data_d  = out_data_q;
        out_cell_d  = out_cell_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_BROADCAST;
                    count_d    = '0;
                    finished_d = '0;
                    ptr_d      = '0;
                end
            end
            S_BROADCAST: begin
                // last counts even on a losing or invalid cycle
                finished_d = finished_q | bus.src_last;
                if (grant_found) begin
                    out_data_d  = bus.src_data[grant_idx*PW +: PW];
                    out_cell_d  = bus.src_dst_cell[grant_idx*CW +: CW];
                    out_valid_d = 1'b1;
                    count_d     = count_q + CNT_WIDTH'(1);
                    ptr_d       = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0
                                                                     : grant_idx + PTR_W'(1);
                end
                if (&finished_d) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                settle_d = SW_W'(SWAP_WAIT - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    settle_d = settle_q - SW_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            finished_q  <= '0;
            count_q     <= '0;
            settle_q    <= '0;
            out_data_q  <= '0;
            out_cell_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            finished_q  <= finished_d;
            count_q     <= count_d;
            settle_q    <= settle_d;
            out_data_q  <= out_data_d;
            out_cell_q  <= out_cell_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.src_ready         = grant;
    assign bus.out_data          = out_data_q;
    assign bus.out_data_dst_cell = out_cell_q;
    assign bus.out_data_valid    = out_valid_q;
    assign motion_update_enable  = (state_q == S_BROADCAST) || (state_q == S_FLUSH);
    assign busy                  = (state_q != S_IDLE);
    assign done                  = (state_q == S_DONE);
    assign broadcast_count       = count_q;
endmodule

// File: tb/tb_mu_broadcast_sched.sv
// Testbench for mu_broadcast_sched: table-driven cycle vectors for the
// single-source, ignored-start and empty passes, plus hand-written sequences
// for contention, mid-pass reset and a cell-cache snoop scenario.
module tb_mu_broadcast_sched;
    localparam int DW   = 32;
    localparam int CIW  = 4;
    localparam int NS   = 4;
    localparam int SW   = 4;
    localparam int CNTW = 16;
    localparam int PW   = 3 * DW;
    localparam int CW   = 3 * CIW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            en;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mu_broadcast_sched_if #(.DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW), .NUM_SRC(NS)) bus ();

    mu_broadcast_sched #(
        .DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW), .NUM_SRC(NS),
        .SWAP_WAIT(SW), .CNT_WIDTH(CNTW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .bus                 (bus),
        .motion_update_enable(en),
        .busy                (busy),
        .done                (done),
        .broadcast_count     (cnt)
    );

    // Particle payload encodes its source and per-source sequence number
    function automatic logic [PW-1:0] mkData(input int src, input int k);
        return {32'(src), 32'(k), 32'hCAFE_0000 + 32'(src * 16 + k)};
    endfunction

    function automatic logic [CW-1:0] mkCell(input int src, input int k);
        return {4'(src), 4'(k), 4'(src + k)};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic [3:0] valid;
        logic [3:0] last;
        int         tag;
        logic       expEn;
        logic       expOv;
        int         expSrc;
        int         expTag;
        logic [3:0] expReady;
        logic       expBusy;
        logic       expDone;
        int         expCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void addRow(input logic s, input logic [3:0] v, input logic [3:0] l,
                                   input int tag, input logic e, input logic ov, input int es,
                                   input int et, input logic [3:0] rdy, input logic b,
                                   input logic d, input int c);
        vec_t r;
        r.start = s; r.valid = v; r.last = l; r.tag = tag;
        r.expEn = e; r.expOv = ov; r.expSrc = es; r.expTag = et;
        r.expReady = rdy; r.expBusy = b; r.expDone = d; r.expCnt = c;
        vecs.push_back(r);
    endfunction

    // Source 0 sends three particles; the others finish immediately.
    // extraStart pulses start in the middle of the pass, which must be ignored.
    function automatic void addSinglePass(input logic extraStart, input int cnt0);
        addRow(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, cnt0);
        addRow(0, 4'h1, 4'hE, 1, 1, 0, 0, 0, 4'h1, 1, 0, 0);
        addRow(0, 4'h1, 4'h0, 2, 1, 1, 0, 1, 4'h1, 1, 0, 1);
        addRow(extraStart, 4'h1, 4'h1, 3, 1, 1, 0, 2, 4'h1, 1, 0, 2);
        addRow(0, 4'h0, 4'h0, 0, 1, 1, 0, 3, 4'h0, 1, 0, 3);
        for (int i = 0; i < 4; i++) addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 3);
        addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 1, 3);
        addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 3);
    endfunction

    function automatic void addEmptyPass(input int cnt0);
        addRow(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, cnt0);
        addRow(0, 4'h0, 4'hF, 0, 1, 0, 0, 0, 4'h0, 1, 0, 0);
        addRow(0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 1, 0, 0);
        for (int i = 0; i < 4; i++) addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0);
        addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 1, 1, 0);
        addRow(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    endfunction

    task automatic driveSources(input logic [3:0] v, input logic [3:0] l, input int tag);
        bus.src_valid = v;
        bus.src_last  = l;
        for (int i = 0; i < NS; i++) begin
            bus.src_data[i*PW +: PW]     = mkData(i, tag);
            bus.src_dst_cell[i*CW +: CW] = mkCell(i, tag);
        end
    endtask

    task automatic applyStimulus(input vec_t r, input int idx);
        start = r.start;
        driveSources(r.valid, r.last, r.tag);
        #2;
        checkOutput($sformatf("row%0d_enable", idx), en, r.expEn);
        checkOutput($sformatf("row%0d_out_valid", idx), bus.out_data_valid, r.expOv);
        checkOutput($sformatf("row%0d_ready", idx), bus.src_ready, r.expReady);
        checkOutput($sformatf("row%0d_busy", idx), busy, r.expBusy);
        checkOutput($sformatf("row%0d_done", idx), done, r.expDone);
        checkOutput($sformatf("row%0d_count", idx), cnt, r.expCnt);
        if (r.expOv) begin
            checkOutput($sformatf("row%0d_out_data", idx), bus.out_data, mkData(r.expSrc, r.expTag));
            checkOutput($sformatf("row%0d_out_cell", idx), bus.out_data_dst_cell,
                        mkCell(r.expSrc, r.expTag));
        end
        @(posedge clk); #1;
    endtask

    // Behavioural pipelines: source i emits numPart[i] particles in order,
    // then asserts last with valid low. Every broadcast beat is recorded.
    int            numPart[NS];
    logic [CW-1:0] cellOf[NS][8];
    logic [PW-1:0] seenData[$];
    logic [CW-1:0] seenCell[$];

    task automatic runPass(output bit finished);
        int         sent[NS];
        logic [3:0] v;
        logic [3:0] l;
        finished = 1'b0;
        seenData.delete();
        seenCell.delete();
        for (int i = 0; i < NS; i++) sent[i] = 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            start = (cyc == 0);
            for (int i = 0; i < NS; i++) begin
                v[i] = (sent[i] < numPart[i]);
                l[i] = !v[i];
                bus.src_data[i*PW +: PW]     = mkData(i, sent[i]);
                bus.src_dst_cell[i*CW +: CW] = (sent[i] < 8) ? cellOf[i][sent[i]] : '0;
            end
            bus.src_valid = v;
            bus.src_last  = l;
            #2;
            if (bus.out_data_valid) begin
                seenData.push_back(bus.out_data);
                seenCell.push_back(bus.out_data_dst_cell);
            end
            if (done) finished = 1'b1;
            for (int i = 0; i < NS; i++) begin
                if (bus.src_ready[i] && v[i]) sent[i]++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        driveSources(4'h0, 4'h0, 0);
    endtask

    task automatic setDefaultCells();
        for (int i = 0; i < NS; i++) begin
            for (int k = 0; k < 8; k++) cellOf[i][k] = mkCell(i, k);
        end
    endtask

    initial begin
        bit            passDone;
        bit            sawDone;
        logic [PW-1:0] expStream[$];
        logic [PW-1:0] cellA[$];
        logic [PW-1:0] cellB[$];

        // Reset state
        rst   = 1'b1;
        start = 1'b0;
        driveSources(4'h0, 4'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("reset_enable", en, 0);
        checkOutput("reset_out_valid", bus.out_data_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ready", bus.src_ready, 0);
        checkOutput("reset_count", cnt, 0);
        checkOutput("reset_out_data", bus.out_data, 0);
        checkOutput("reset_out_cell", bus.out_data_dst_cell, 0);
        @(posedge clk); #1;

        // Single source pass, same pass with a stray start, then an empty pass
        addSinglePass(1'b0, 0);
        addSinglePass(1'b1, 3);
        addEmptyPass(3);
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Contention between sources 0 and 2, two particles each
        setDefaultCells();
        numPart = '{2, 0, 2, 0};
        runPass(passDone);
        checkOutput("contend_done", passDone, 1);
        checkOutput("contend_count", cnt, 4);
        expStream = '{mkData(0, 0), mkData(2, 0), mkData(0, 1), mkData(2, 1)};
        checkOutput("contend_beats", seenData.size(), 4);
        for (int i = 0; i < 4 && i < seenData.size(); i++)
            checkOutput($sformatf("contend_beat%0d", i), seenData[i], expStream[i]);

        // Reset after two transfers aborts the pass
        start = 1'b1;
        driveSources(4'h0, 4'h0, 0);
        @(posedge clk); #1;
        start = 1'b0;
        driveSources(4'h1, 4'hE, 1);
        @(posedge clk); #1;
        driveSources(4'h1, 4'h0, 2);
        @(posedge clk); #1;
        driveSources(4'h1, 4'h0, 3);
        #2;
        checkOutput("abort_pre_count", cnt, 2);
        checkOutput("abort_pre_enable", en, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        driveSources(4'h0, 4'h0, 0);
        #2;
        checkOutput("abort_enable", en, 0);
        checkOutput("abort_out_valid", bus.out_data_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", cnt, 0);
        checkOutput("abort_done", done, 0);
        sawDone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #3;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abort_no_done", sawDone, 0);
        @(posedge clk); #1;
        numPart = '{0, 1, 0, 0};
        runPass(passDone);
        checkOutput("after_abort_done", passDone, 1);
        checkOutput("after_abort_count", cnt, 1);
        checkOutput("after_abort_beats", seenData.size(), 1);
        if (seenData.size() > 0) checkOutput("after_abort_beat0", seenData[0], mkData(1, 0));

        // Cache snoop: 5 particles to cell (4,2,4) and 2 to cell (1,1,1)
        setDefaultCells();
        numPart = '{0, 3, 0, 4};
        for (int k = 0; k < 3; k++) cellOf[1][k] = 12'h424;
        cellOf[3][0] = 12'h424;
        cellOf[3][1] = 12'h424;
        cellOf[3][2] = 12'h111;
        cellOf[3][3] = 12'h111;
        runPass(passDone);
        checkOutput("cache_done", passDone, 1);
        checkOutput("cache_count", cnt, 7);
        for (int i = 0; i < seenData.size(); i++) begin
            if (seenCell[i] == 12'h424) cellA.push_back(seenData[i]);
            else if (seenCell[i] == 12'h111) cellB.push_back(seenData[i]);
        end
        checkOutput("cache_424_num", cellA.size(), 5);
        checkOutput("cache_111_num", cellB.size(), 2);
        expStream = '{mkData(1, 0), mkData(3, 0), mkData(1, 1), mkData(3, 1), mkData(1, 2)};
        for (int i = 0; i < 5 && i < cellA.size(); i++)
            checkOutput($sformatf("cache_424_addr%0d", i + 1), cellA[i], expStream[i]);
        expStream = '{mkData(3, 2), mkData(3, 3)};
        for (int i = 0; i < 2 && i < cellB.size(); i++)
            checkOutput($sformatf("cache_111_addr%0d", i + 1), cellB[i], expStream[i]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
